// File: rtl/tic_tac_toe_match_ctrl.sv
// tic_tac_toe_match_ctrl
// Match sequencer placed in front of the tic_tac_toe board datapath.
// It forwards only the active player's buttons to the board and enforces a
// per-move tick budget; running out of ticks forfeits the game. It scores
// each finished game, holds the result for a while, then restarts the board
// until one player has WINS_TO_MATCH game wins.
//
// Ports:
//   Clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begins a match from IDLE or MATCH_DONE
//   tick_in      one-cycle timebase pulse used for the move timeout
//   p1_btn       player 1 buttons {L,R,U,D,C}
//   p2_btn       player 2 buttons {L,R,U,D,C}
//   moved        board PlayerMoved pulse
//   p1_won       board P1Won
//   p2_won       board P2Won
//   board_full   all nine cells occupied
//   btn_out      buttons forwarded to the board (registered)
//   restart      one-cycle board restart pulse
//   turn         0 = player 1 to move, 1 = player 2
//   time_left    ticks remaining for the current move
//   p1_score     games won by player 1 this match
//   p2_score     games won by player 2 this match
//   draws        drawn games this match
//   match_over   high while the match is finished
//   match_winner 01 = player 1, 10 = player 2, 00 = none
//   state        current FSM state (debug)
module tic_tac_toe_match_ctrl #(
    parameter int TIMEOUT_TICKS = 10,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int WINS_TO_MATCH = 3
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       tick_in,
    input  logic [4:0] p1_btn,
    input  logic [4:0] p2_btn,
    input  logic       moved,
    input  logic       p1_won,
    input  logic       p2_won,
    input  logic       board_full,
    output logic [4:0] btn_out,
    output logic       restart,
    output logic       turn,
    output logic [7:0] time_left,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [3:0] draws,
    output logic       match_over,
    output logic [1:0] match_winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESTART    = 3'd1,
        ST_WAIT_MOVE  = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_RESULT     = 3'd4,
        ST_MATCH_DONE = 3'd5
    } state_t;

    localparam int              HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [7:0]      TIME_RELOAD = 8'(TIMEOUT_TICKS);
    localparam logic [3:0]      WINS        = 4'(WINS_TO_MATCH);

    // Counters stick at 15 so a long match never wraps back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    state_t            state_r, state_s;
    logic [4:0]        btn_out_r, btn_out_s;
    logic              restart_r, restart_s;
    logic              turn_r, turn_s;
    logic [7:0]        time_left_r, time_left_s;
    logic [3:0]        p1_score_r, p1_score_s;
    logic [3:0]        p2_score_r, p2_score_s;
    logic [3:0]        draws_r, draws_s;
    logic              match_over_r, match_over_s;
    logic [1:0]        match_winner_r, match_winner_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;

    // Next-state and next-output logic for the match sequencer.
    always_comb begin
        state_s        = state_r;
        btn_out_s      = 5'd0;
        restart_s      = 1'b0;
        turn_s         = turn_r;
        time_left_s    = time_left_r;
        p1_score_s     = p1_score_r;
        p2_score_s     = p2_score_r;
        draws_s        = draws_r;
        match_over_s   = match_over_r;
        match_winner_s = match_winner_r;
        hold_cnt_s     = {HOLD_W{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    p1_score_s     = 4'd0;
                    p2_score_s     = 4'd0;
                    draws_s        = 4'd0;
                    match_winner_s = 2'b00;
                    restart_s      = 1'b1;
                    turn_s         = 1'b0;
                    time_left_s    = TIME_RELOAD;
                    state_s        = ST_RESTART;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RESTART: begin
                state_s = ST_WAIT_MOVE;
            end

            ST_WAIT_MOVE: begin
                if (tick_in) begin
                    time_left_s = time_left_r - 8'd1;
                end else begin
                    time_left_s = time_left_r;
                end
                // A move landing on the final tick beats the forfeit.
                if (moved) begin
                    state_s = ST_SETTLE;
                end else if (tick_in && (time_left_r <= 8'd1)) begin
                    time_left_s = 8'd0;
                    if (turn_r) begin
                        p1_score_s = sat_inc(p1_score_r);
                    end else begin
                        p2_score_s = sat_inc(p2_score_r);
                    end
                    state_s = ST_RESULT;
                end else begin
                    btn_out_s = turn_r ? p2_btn : p1_btn;
                end
            end

            ST_SETTLE: begin
                if (p1_won) begin
                    p1_score_s = sat_inc(p1_score_r);
                    state_s    = ST_RESULT;
                end else if (p2_won) begin
                    p2_score_s = sat_inc(p2_score_r);
                    state_s    = ST_RESULT;
                end else if (board_full) begin
                    draws_s = sat_inc(draws_r);
                    state_s = ST_RESULT;
                end else begin
                    turn_s      = ~turn_r;
                    time_left_s = TIME_RELOAD;
                    state_s     = ST_WAIT_MOVE;
                end
            end

            ST_RESULT: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    if (p1_score_r == WINS) begin
                        match_winner_s = 2'b01;
                        match_over_s   = 1'b1;
                        state_s        = ST_MATCH_DONE;
                    end else if (p2_score_r == WINS) begin
                        match_winner_s = 2'b10;
                        match_over_s   = 1'b1;
                        state_s        = ST_MATCH_DONE;
                    end else begin
                        restart_s   = 1'b1;
                        turn_s      = 1'b0;
                        time_left_s = TIME_RELOAD;
                        state_s     = ST_RESTART;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end

            ST_MATCH_DONE: begin
                if (start) begin
                    p1_score_s     = 4'd0;
                    p2_score_s     = 4'd0;
                    draws_s        = 4'd0;
                    match_winner_s = 2'b00;
                    match_over_s   = 1'b0;
                    restart_s      = 1'b1;
                    turn_s         = 1'b0;
                    time_left_s    = TIME_RELOAD;
                    state_s        = ST_RESTART;
                end else begin
                    state_s = ST_MATCH_DONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any game in progress.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            btn_out_r      <= 5'd0;
            restart_r      <= 1'b0;
            turn_r         <= 1'b0;
            time_left_r    <= TIME_RELOAD;
            p1_score_r     <= 4'd0;
            p2_score_r     <= 4'd0;
            draws_r        <= 4'd0;
            match_over_r   <= 1'b0;
            match_winner_r <= 2'b00;
            hold_cnt_r     <= {HOLD_W{1'b0}};
        end else begin
            state_r        <= state_s;
            btn_out_r      <= btn_out_s;
            restart_r      <= restart_s;
            turn_r         <= turn_s;
            time_left_r    <= time_left_s;
            p1_score_r     <= p1_score_s;
            p2_score_r     <= p2_score_s;
            draws_r        <= draws_s;
            match_over_r   <= match_over_s;
            match_winner_r <= match_winner_s;
            hold_cnt_r     <= hold_cnt_s;
        end
    end

    assign btn_out      = btn_out_r;
    assign restart      = restart_r;
    assign turn         = turn_r;
    assign time_left    = time_left_r;
    assign p1_score     = p1_score_r;
    assign p2_score     = p2_score_r;
    assign draws        = draws_r;
    assign match_over   = match_over_r;
    assign match_winner = match_winner_r;
    assign state        = state_r;

endmodule
